// File: rtl/apex_meta_regs.sv
// ---------------------------------------------------------------------------
// apex_meta_regs
//
// Memory-mapped metadata register file in front of the VRASED/APEX monitor.
// Software programs the executable-region (ER) and output-region (OR) bounds
// over the openMSP430 peripheral bus. The block forwards those bounds to the
// monitor, reports the monitor's exec flag, flags inconsistent bounds, and
// counts (saturating) how often exec has dropped.
//
// Word map (offset from META_BASE, word index):
//   0 ER_MIN  RW     1 ER_MAX  RW     2 OR_MIN  RW     3 OR_MAX  RW
//   4 STATUS  RO     [0]=exec_q [1]=cfg_err [15:8]=drop_cnt
//   5 CTRL    W: [0]=1 clears drop_cnt (pulse), [1]=LOCK set (feature only)
//             R: [1]=lock, other bits 0
//   6,7       reserved, read 0, writes ignored
//
// Ports:
//   clk       system clock
//   puc       synchronous active-high reset
//   per_en    peripheral access strobe
//   per_addr  word address (byte address >> 1)
//   per_we    byte write enables ([0]=low, [1]=high), 2'b00 = read
//   per_din   write data
//   per_dout  registered read data, valid the cycle after the read strobe
//   exec      exec flag from the monitor
//   ER_min/ER_max/OR_min/OR_max  bound registers towards the monitor
//   cfg_err   1 when ER_min > ER_max or OR_min > OR_max (unsigned)
//
// Optional feature, macro META_WRLOCK_EN:
//   Adds a set-only LOCK bit (CTRL[1], cleared only by puc) and an exec-phase
//   FSM. Bound writes are dropped while locked or while the FSM is in RUN.
//   Without the macro, CTRL[1] reads 0 and bounds are always writable.
// ---------------------------------------------------------------------------
module apex_meta_regs #(
  parameter logic [15:0] META_BASE  = 16'h0140,
  parameter logic [15:0] ER_MIN_RST = 16'hE000,
  parameter logic [15:0] ER_MAX_RST = 16'hE500,
  parameter logic [15:0] OR_MIN_RST = 16'hF000,
  parameter logic [15:0] OR_MAX_RST = 16'hF004
) (
  input  logic        clk,
  input  logic        puc,
  input  logic        per_en,
  input  logic [13:0] per_addr,
  input  logic [1:0]  per_we,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  input  logic        exec,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic [15:0] OR_min,
  output logic [15:0] OR_max,
  output logic        cfg_err
);

  // The peripheral bus is word addressed; the window base is a byte address.
  localparam logic [13:0] BASE_WORD = META_BASE[14:1];

  localparam logic [3:0][15:0] BOUND_RST = {OR_MAX_RST, OR_MIN_RST,
                                            ER_MAX_RST, ER_MIN_RST};

  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;

  // ---------------------------------------------------------------------
  // Address decode. The subtraction wraps for addresses below the base, so
  // a single test on the upper bits covers both sides of the window.
  // ---------------------------------------------------------------------
  logic [13:0] w_idx;
  logic [2:0]  w_off;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;

  assign w_idx = per_addr - BASE_WORD;
  assign w_off = w_idx[2:0];
  assign w_hit = per_en && (w_idx[13:3] == 11'd0);
  assign w_wr  = w_hit && (per_we != 2'b00);
  assign w_rd  = w_hit && (per_we == 2'b00);

  // ---------------------------------------------------------------------
  // Exec tracking
  // ---------------------------------------------------------------------
  logic       r_exec_q;
  logic       w_drop;
  logic [7:0] r_drop_cnt;
  logic       w_clr;

  assign w_drop = r_exec_q && !exec;
  assign w_clr  = w_wr && (w_off == OFF_CTRL) && per_we[0] && per_din[0];

  always_ff @(posedge clk) begin
    if (puc) begin
      r_exec_q <= 1'b0;
    end else begin
      r_exec_q <= exec;
    end
  end

  // Clear has priority over a simultaneous drop.
  always_ff @(posedge clk) begin
    if (puc) begin
      r_drop_cnt <= 8'd0;
    end else if (w_clr) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Write qualifier for the bound registers, plus lock and exec phase
  // ---------------------------------------------------------------------
  logic w_bound_wr_ok;
  logic w_lock_rd;

`ifdef META_WRLOCK_EN
  typedef enum logic {ST_IDLE, ST_RUN} phase_t;

  phase_t r_state;
  phase_t w_state_next;
  logic   r_lock;
  logic   w_rise;

  assign w_rise = !r_exec_q && exec;

  always_ff @(posedge clk) begin
    if (puc) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_next = ST_RUN;
      ST_RUN:  if (w_drop) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Set-only: once software locks the bounds only a reset releases them.
  always_ff @(posedge clk) begin
    if (puc) begin
      r_lock <= 1'b0;
    end else if (w_wr && (w_off == OFF_CTRL) && per_we[0] && per_din[1]) begin
      r_lock <= 1'b1;
    end
  end

  assign w_bound_wr_ok = !r_lock && (r_state == ST_IDLE);
  assign w_lock_rd     = r_lock;
`else
  assign w_bound_wr_ok = 1'b1;
  assign w_lock_rd     = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Bound registers (offsets 0..3), byte-granular writes
  // ---------------------------------------------------------------------
  logic [15:0] w_bound [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bound
      logic [15:0] r_val;

      always_ff @(posedge clk) begin
        if (puc) begin
          r_val <= BOUND_RST[gi];
        end else if (w_wr && (w_off == 3'(gi)) && w_bound_wr_ok) begin
          if (per_we[1]) r_val[15:8] <= per_din[15:8];
          if (per_we[0]) r_val[7:0]  <= per_din[7:0];
        end
      end

      assign w_bound[gi] = r_val;
    end
  endgenerate

  assign ER_min  = w_bound[0];
  assign ER_max  = w_bound[1];
  assign OR_min  = w_bound[2];
  assign OR_max  = w_bound[3];
  assign cfg_err = (w_bound[0] > w_bound[1]) || (w_bound[2] > w_bound[3]);

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [15:0] w_rdata;
  logic [15:0] r_dout;

  always_comb begin
    w_rdata = 16'h0000;
    case (w_off)
      3'd0, 3'd1, 3'd2, 3'd3: w_rdata = w_bound[w_off[1:0]];
      OFF_STATUS:             w_rdata = {r_drop_cnt, 6'b000000, cfg_err, r_exec_q};
      OFF_CTRL:               w_rdata = {14'd0, w_lock_rd, 1'b0};
      default:                w_rdata = 16'h0000;
    endcase
  end

  // Data is only presented for a read hit; writes and idle cycles return 0.
  always_ff @(posedge clk) begin
    if (puc) begin
      r_dout <= 16'h0000;
    end else if (w_rd) begin
      r_dout <= w_rdata;
    end else begin
      r_dout <= 16'h0000;
    end
  end

  assign per_dout = r_dout;

endmodule
